// File: rtl/sobel_pkg.sv
// Shared encodings and width helpers for the multi-channel 3x3 edge core.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_SAT   = 2'd0,
    MODE_THR   = 2'd1,
    MODE_SCALE = 2'd2,
    MODE_SAT3  = 2'd3
  } mode_e;

  typedef enum logic {
    KER_SOBEL   = 1'b0,
    KER_PREWITT = 1'b1
  } kernel_e;

  // GRAD_W = DATA_W+3 (signed gradient), MAG_W = DATA_W+4 (|GX|+|GY|)
  function automatic int grad_w(input int data_w);
    return data_w + 3;
  endfunction

  function automatic int mag_w(input int data_w);
    return data_w + 4;
  endfunction

  // Control carried alongside each pixel through the shared pipeline.
  typedef struct packed {
    logic       v;
    logic       border;
    logic       eol;
    logic       ker;
    logic [1:0] mode;
  } stage_t;

endpackage

// File: rtl/sobel_edge_pipe_if.sv
// Row-tap input bundle and result output bundle of the edge core.
interface sobel_edge_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CH     = 3
);
  // Valid-only stream: no ready; the core accepts a column on every cycle
  // valid_in is high and returns exactly one valid_out three cycles later.
  logic                   valid_in;
  logic                   sol_in;
  logic [CH*DATA_W-1:0]   din1;
  logic [CH*DATA_W-1:0]   din2;
  logic [CH*DATA_W-1:0]   din3;
  logic                   kernel_sel;
  logic [1:0]             mode;
  logic [DATA_W+3:0]      thresh;
  logic [CH*DATA_W-1:0]   dout;
  logic                   valid_out;
  logic                   eol_out;

  modport master (
    output valid_in, sol_in, din1, din2, din3, kernel_sel, mode, thresh,
    input  dout, valid_out, eol_out
  );

  modport slave (
    input  valid_in, sol_in, din1, din2, din3, kernel_sel, mode, thresh,
    output dout, valid_out, eol_out
  );
endinterface

// File: rtl/sobel_grad_ch.sv
// One channel: 3x3 window, GX/GY, L1 magnitude and output mapping.
module sobel_grad_ch
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] top_i,
  input  logic [DATA_W-1:0] mid_i,
  input  logic [DATA_W-1:0] bot_i,
  input  logic              ker_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W+3:0] thresh_i,
  input  logic              border_i,
  input  logic              load_i,
  output logic [DATA_W-1:0] dout_o
);
  localparam int GRAD_W = grad_w(DATA_W);
  localparam int MAG_W  = mag_w(DATA_W);
  localparam logic [MAG_W-1:0] MAX_OUT = MAG_W'((1 << DATA_W) - 1);

  // index 0 = newest column c, index 2 = column c-2
  logic [2:0][DATA_W-1:0] top_q, mid_q, bot_q;
  logic [GRAD_W-1:0]      gx_d, gx_q, gy_d, gy_q;
  logic [MAG_W-1:0]       mag_d, mag_q, scaled;
  logic [DATA_W-1:0]      map_d, dout_q;

  function automatic logic [GRAD_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c,
                                             input logic ker);
    logic [GRAD_W-1:0] mid_term;
    mid_term = (ker == KER_PREWITT) ? GRAD_W'(b) : GRAD_W'({b, 1'b0});
    return GRAD_W'(a) + mid_term + GRAD_W'(c);
  endfunction

  function automatic logic [GRAD_W-1:0] absv(input logic [GRAD_W-1:0] v);
    return v[GRAD_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic [MAG_W-1:0] v);
    return (v > MAX_OUT) ? MAX_OUT[DATA_W-1:0] : v[DATA_W-1:0];
  endfunction

  always_comb begin
    gx_d   = wsum(top_q[0], mid_q[0], bot_q[0], ker_i)
           - wsum(top_q[2], mid_q[2], bot_q[2], ker_i);
    gy_d   = wsum(bot_q[2], bot_q[1], bot_q[0], ker_i)
           - wsum(top_q[2], top_q[1], top_q[0], ker_i);
    mag_d  = MAG_W'(absv(gx_q)) + MAG_W'(absv(gy_q));
    scaled = mag_q >> 2;
    map_d  = sat(mag_q);
    case (mode_i)
      MODE_THR:   map_d = (mag_q >= thresh_i) ? '1 : '0;
      MODE_SCALE: map_d = sat(scaled);
      default:    ;
    endcase
    if (border_i) map_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q  <= '0;
      mid_q  <= '0;
      bot_q  <= '0;
      gx_q   <= '0;
      gy_q   <= '0;
      mag_q  <= '0;
      dout_q <= '0;
    end else begin
      if (shift_i) begin
        top_q <= {top_q[1:0], top_i};
        mid_q <= {mid_q[1:0], mid_i};
        bot_q <= {bot_q[1:0], bot_i};
      end
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      mag_q <= mag_d;
      if (load_i) dout_q <= map_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/sobel_edge_pipe.sv
// Multi-channel 3x3 Sobel/Prewitt edge core: column tracking, per-line
// config capture and the control pipeline shared by all channel datapaths.
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter int PIC_WIDTH = 250,
  parameter int DATA_W    = 8,
  parameter int CH        = 3
) (
  input logic              clk,
  input logic              rst,
  sobel_edge_pipe_if.slave bus
);
  localparam logic [10:0] LAST_COL = 11'(PIC_WIDTH - 1);

  // col_q is the column the next accepted pixel will take
  logic [10:0]        col_q, col_d, this_col;
  logic               ker_q, ker_cur;
  logic [1:0]         mode_q, mode_cur;
  logic [DATA_W+3:0]  thr_q, thr_cur;
  logic               first;
  stage_t             st1_q, st2_q, st3_q, st_d;
  logic [DATA_W+3:0]  thr1_q, thr2_q, thr3_q;
  logic               valid_out_q, eol_out_q;
  logic [CH*DATA_W-1:0] dout_w;

  always_comb begin
    this_col  = bus.sol_in ? 11'd0 : col_q;
    first     = (this_col == 11'd0);
    col_d     = col_q;
    if (bus.valid_in) col_d = (this_col == LAST_COL) ? 11'd0 : this_col + 11'd1;
    // a column-0 pixel already uses the config it carries in
    ker_cur   = first ? bus.kernel_sel : ker_q;
    mode_cur  = first ? bus.mode       : mode_q;
    thr_cur   = first ? bus.thresh     : thr_q;
    st_d.v      = bus.valid_in;
    st_d.border = (this_col < 11'd2);
    st_d.eol    = (this_col == LAST_COL);
    st_d.ker    = ker_cur;
    st_d.mode   = mode_cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      ker_q       <= KER_SOBEL;
      mode_q      <= MODE_SAT;
      thr_q       <= '0;
      st1_q       <= '0;
      st2_q       <= '0;
      st3_q       <= '0;
      thr1_q      <= '0;
      thr2_q      <= '0;
      thr3_q      <= '0;
      valid_out_q <= 1'b0;
      eol_out_q   <= 1'b0;
    end else begin
      col_q <= col_d;
      if (bus.valid_in && first) begin
        ker_q  <= bus.kernel_sel;
        mode_q <= bus.mode;
        thr_q  <= bus.thresh;
      end
      st1_q       <= st_d;
      thr1_q      <= thr_cur;
      st2_q       <= st1_q;
      thr2_q      <= thr1_q;
      st3_q       <= st2_q;
      thr3_q      <= thr2_q;
      valid_out_q <= st3_q.v;
      eol_out_q   <= st3_q.v & st3_q.eol;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    sobel_grad_ch #(.DATA_W(DATA_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .shift_i  (bus.valid_in),
      .top_i    (bus.din1[g*DATA_W +: DATA_W]),
      .mid_i    (bus.din2[g*DATA_W +: DATA_W]),
      .bot_i    (bus.din3[g*DATA_W +: DATA_W]),
      .ker_i    (st1_q.ker),
      .mode_i   (st3_q.mode),
      .thresh_i (thr3_q),
      .border_i (st3_q.border),
      .load_i   (st3_q.v),
      .dout_o   (dout_w[g*DATA_W +: DATA_W])
    );
  end

  assign bus.dout      = dout_w;
  assign bus.valid_out = valid_out_q;
  assign bus.eol_out   = eol_out_q;

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Directed bench for sobel_edge_pipe: vertical-step images on 8-pixel lines.
module tb_sobel_edge_pipe;
  localparam int W  = 8;
  localparam int DW = 8;
  localparam int CH = 3;

  typedef struct packed {
    logic [7:0]      lo;
    logic [7:0]      hi;
    logic            ker;
    logic [1:0]      md;
    logic [11:0]     th;
    logic            gap;
    logic [7:0][7:0] e;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_edge_pipe_if #(.DATA_W(DW), .CH(CH)) bus ();

  sobel_edge_pipe #(.PIC_WIDTH(W), .DATA_W(DW), .CH(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [CH*DW-1:0] got_q[$];
  logic             got_eol_q[$];
  int               got_cyc_q[$];
  int               acc_cyc_q[$];
  logic [DW-1:0]    exp_q[$];
  logic             exp_eol_q[$];
  logic [CH*DW-1:0] last_dout = '0;

  vec_t vecs[10];

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: capture outputs, check dout holds and no stray eol while idle
  always @(posedge clk) begin
    #1;
    if (rst) begin
      last_dout = '0;
    end else if (bus.valid_out) begin
      got_q.push_back(bus.dout);
      got_eol_q.push_back(bus.eol_out);
      got_cyc_q.push_back(cyc);
      last_dout = bus.dout;
    end else begin
      total++;
      if (bus.dout !== last_dout || bus.eol_out !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d dout=%h eol=%b required dout=%h eol=0",
                 cyc, bus.dout, bus.eol_out, last_dout);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [DW-1:0] v, input logic sol, input logic ker,
                       input logic [1:0] md, input logic [11:0] th, input logic r);
    @(negedge clk);
    rst            = r;
    bus.valid_in   = 1'b1;
    bus.sol_in     = sol;
    bus.din1       = {CH{v}};
    bus.din2       = {CH{v}};
    bus.din3       = {CH{v}};
    bus.kernel_sel = ker;
    bus.mode       = md;
    bus.thresh     = th;
    if (!r) acc_cyc_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rst          = 1'b0;
      bus.valid_in = 1'b0;
      bus.sol_in   = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] pix(input int c, input logic [DW-1:0] lo,
                                        input logic [DW-1:0] hi);
    return (c >= 3) ? hi : lo;
  endfunction

  function automatic logic [7:0][7:0] step_e(input logic [7:0] v);
    logic [7:0][7:0] e;
    e    = '0;
    e[3] = v;
    e[4] = v;
    return e;
  endfunction

  task automatic expect_line(input logic [7:0][7:0] e, input int n, input logic eol_last);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(e[i]);
      exp_eol_q.push_back(eol_last && (i == n - 1));
    end
  endtask

  // scoreboard
  task automatic check_outputs(input string name);
    int n;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s count got=%0d required=%0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_q[i] !== {CH{exp_q[i]}}) begin
        bad++;
        $display("FAIL %s dout[%0d] got=%h required=%h", name, i, got_q[i], {CH{exp_q[i]}});
      end
      total++;
      if (got_eol_q[i] !== exp_eol_q[i]) begin
        bad++;
        $display("FAIL %s eol[%0d] got=%b required=%b", name, i, got_eol_q[i], exp_eol_q[i]);
      end
      if (i < acc_cyc_q.size()) begin
        total++;
        if (got_cyc_q[i] - acc_cyc_q[i] != 3) begin
          bad++;
          $display("FAIL %s latency[%0d] got=%0d required=3", name, i,
                   got_cyc_q[i] - acc_cyc_q[i]);
        end
      end
    end
    got_q.delete(); got_eol_q.delete(); got_cyc_q.delete();
    acc_cyc_q.delete(); exp_q.delete(); exp_eol_q.delete();
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.sol_in = 1'b0;
    bus.din1 = '0; bus.din2 = '0; bus.din3 = '0;
    bus.kernel_sel = 1'b0; bus.mode = 2'd0; bus.thresh = '0;

    vecs[0] = '{lo:8'd100, hi:8'd100, ker:1'b0, md:2'd0, th:12'd0,  gap:1'b0, e:'0};
    vecs[1] = '{lo:8'd0,   hi:8'd20,  ker:1'b0, md:2'd0, th:12'd0,  gap:1'b0, e:step_e(8'd80)};
    vecs[2] = '{lo:8'd0,   hi:8'd20,  ker:1'b1, md:2'd0, th:12'd0,  gap:1'b0, e:step_e(8'd60)};
    vecs[3] = '{lo:8'd0,   hi:8'd20,  ker:1'b0, md:2'd2, th:12'd0,  gap:1'b0, e:step_e(8'd20)};
    vecs[4] = '{lo:8'd0,   hi:8'd255, ker:1'b0, md:2'd0, th:12'd0,  gap:1'b0, e:step_e(8'd255)};
    vecs[5] = '{lo:8'd0,   hi:8'd20,  ker:1'b0, md:2'd1, th:12'd80, gap:1'b0, e:step_e(8'd255)};
    vecs[6] = '{lo:8'd0,   hi:8'd20,  ker:1'b0, md:2'd1, th:12'd81, gap:1'b0, e:'0};
    vecs[7] = '{lo:8'd0,   hi:8'd20,  ker:1'b0, md:2'd1, th:12'd0,  gap:1'b0,
                e:64'hFFFF_FFFF_FFFF_0000};
    vecs[8] = '{lo:8'd0,   hi:8'd20,  ker:1'b0, md:2'd3, th:12'd0,  gap:1'b0, e:step_e(8'd80)};
    vecs[9] = '{lo:8'd0,   hi:8'd20,  ker:1'b0, md:2'd0, th:12'd0,  gap:1'b1, e:step_e(8'd80)};

    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.eol_out !== 1'b0 || bus.dout !== '0) begin
      bad++;
      $display("FAIL reset_state valid=%b eol=%b dout=%h required 0/0/0",
               bus.valid_out, bus.eol_out, bus.dout);
    end
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 10; v++) begin
      for (int c = 0; c < W; c++) begin
        drive(pix(c, vecs[v].lo, vecs[v].hi), c == 0, vecs[v].ker, vecs[v].md, vecs[v].th, 1'b0);
        if (vecs[v].gap) idle(1);
      end
      idle(6);
      expect_line(vecs[v].e, W, 1'b1);
      check_outputs($sformatf("vec%0d", v));
    end

    // kernel_sel flipped mid-line: Sobel until end of line, Prewitt on the next
    for (int c = 0; c < W; c++) drive(pix(c, 8'd0, 8'd20), c == 0, c >= 4, 2'd0, 12'd0, 1'b0);
    for (int c = 0; c < W; c++) drive(pix(c, 8'd0, 8'd20), c == 0, 1'b1, 2'd0, 12'd0, 1'b0);
    idle(6);
    expect_line(step_e(8'd80), W, 1'b1);
    expect_line(step_e(8'd60), W, 1'b1);
    check_outputs("kernel_change");

    // sol_in at column 5 truncates; a sol_in without valid_in is ignored
    for (int c = 0; c < 5; c++) drive(pix(c, 8'd0, 8'd20), c == 0, 1'b0, 2'd0, 12'd0, 1'b0);
    for (int c = 0; c < W; c++) begin
      drive(pix(c, 8'd0, 8'd20), c == 0, 1'b0, 2'd0, 12'd0, 1'b0);
      if (c == 2) begin
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.sol_in   = 1'b1;
      end
    end
    idle(6);
    expect_line(step_e(8'd80), 5, 1'b0);
    expect_line(step_e(8'd80), W, 1'b1);
    check_outputs("sol_truncate");

    // reset at column 4: in-flight pixels dropped, restart at column 0 without sol_in
    for (int c = 0; c < 4; c++) drive(pix(c, 8'd0, 8'd20), c == 0, 1'b0, 2'd0, 12'd0, 1'b0);
    drive(pix(4, 8'd0, 8'd20), 1'b0, 1'b0, 2'd0, 12'd0, 1'b1);
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.eol_out !== 1'b0 || bus.dout !== '0) begin
      bad++;
      $display("FAIL mid_reset valid=%b eol=%b dout=%h required 0/0/0",
               bus.valid_out, bus.eol_out, bus.dout);
    end
    rst = 1'b0;
    bus.valid_in = 1'b0;
    idle(5);
    expect_line('0, 1, 1'b0);
    check_outputs("reset_drop");
    for (int c = 0; c < W; c++) drive(pix(c, 8'd0, 8'd20), 1'b0, 1'b0, 2'd0, 12'd0, 1'b0);
    idle(6);
    expect_line(step_e(8'd80), W, 1'b1);
    check_outputs("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
